// File: rtl/dram_read_master.sv
// AXI4 read master for single-burst DRAM read requests. A request that crosses
// a 4 KiB page is issued as two back-to-back bursts with one AR in flight.
module dram_read_master #(
  parameter int          DRAM_ADDR_WIDTH = 39,
  parameter int          DRAM_DATA_WIDTH = 128,
  parameter logic [15:0] AXI_ID          = 16'd0
) (
  input  logic                       s_axi_aclk,
  input  logic                       s_axi_aresetn,
  input  logic [DRAM_ADDR_WIDTH-1:0] dram_read_addr,
  input  logic [7:0]                 dram_read_len,
  input  logic                       dram_read_en,
  input  logic                       dram_buffer_full,
  output logic [DRAM_DATA_WIDTH-1:0] dram_read_data,
  output logic                       dram_read_data_valid,
  output logic                       dram_read_busy,
  output logic                       dram_read_error,
  output logic [DRAM_ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]                 m_axi_arlen,
  output logic [2:0]                 m_axi_arsize,
  output logic [1:0]                 m_axi_arburst,
  output logic [15:0]                m_axi_arid,
  output logic                       m_axi_arvalid,
  input  logic                       m_axi_arready,
  input  logic [DRAM_DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]                 m_axi_rresp,
  input  logic                       m_axi_rlast,
  input  logic                       m_axi_rvalid,
  output logic                       m_axi_rready,
  input  logic [15:0]                m_axi_rid
);
  localparam int BPB      = DRAM_DATA_WIDTH / 8;
  localparam int BPB_LOG2 = $clog2(BPB);
  localparam logic [DRAM_ADDR_WIDTH-1:0] BEAT_MASK = DRAM_ADDR_WIDTH'(BPB - 1);
  localparam logic [DRAM_ADDR_WIDTH-1:0] PAGE_MASK = DRAM_ADDR_WIDTH'(4095);
  localparam logic [DRAM_ADDR_WIDTH-1:0] PAGE      = DRAM_ADDR_WIDTH'(4096);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  typedef struct packed {
    logic [DRAM_ADDR_WIDTH-1:0] addr;
    logic [7:0]                 len;
  } burst_t;

  state_t state, state_d;
  burst_t cur, nxt;
  logic   nxt_pend;
  logic [8:0] beat_cnt;

  logic [DRAM_ADDR_WIDTH-1:0] req_addr;
  logic [12:0] page_left, bnd_beats;
  logic        split;
  burst_t      b1, b2;
  logic        r_hs, last_beat;
  logic        unused_rid;

  assign unused_rid = ^m_axi_rid;

  // Page split: B beats fit before the boundary; split when N = len+1 > B.
  assign req_addr  = dram_read_addr & ~BEAT_MASK;
  assign page_left = 13'd4096 - {1'b0, req_addr[11:0]};
  assign bnd_beats = page_left >> BPB_LOG2;
  assign split     = {5'd0, dram_read_len} >= bnd_beats;
  assign b1.addr   = req_addr;
  assign b1.len    = split ? bnd_beats[7:0] - 8'd1 : dram_read_len;
  assign b2.addr   = (req_addr & ~PAGE_MASK) + PAGE;
  assign b2.len    = dram_read_len - bnd_beats[7:0];

  assign r_hs      = m_axi_rvalid && m_axi_rready;
  assign last_beat = (beat_cnt == 9'd1);

  assign m_axi_araddr   = cur.addr;
  assign m_axi_arlen    = cur.len;
  assign m_axi_arsize   = 3'(BPB_LOG2);
  assign m_axi_arburst  = 2'b01;
  assign m_axi_arid     = AXI_ID;
  assign m_axi_arvalid  = (state == ADDR);
  assign m_axi_rready   = (state == DATA) && !dram_buffer_full;
  assign dram_read_busy = (state != IDLE);

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) state <= IDLE;
    else                state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE: if (dram_read_en)  state_d = ADDR;
      ADDR: if (m_axi_arready) state_d = DATA;
      DATA: if (r_hs && last_beat) state_d = nxt_pend ? ADDR : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      cur                  <= '0;
      nxt                  <= '0;
      nxt_pend             <= 1'b0;
      beat_cnt             <= '0;
      dram_read_data       <= '0;
      dram_read_data_valid <= 1'b0;
      dram_read_error      <= 1'b0;
    end else begin
      dram_read_data_valid <= r_hs;
      if (r_hs) dram_read_data <= m_axi_rdata;
      case (state)
        IDLE: if (dram_read_en) begin
          cur      <= b1;
          nxt      <= b2;
          nxt_pend <= split;
        end
        ADDR: if (m_axi_arready) beat_cnt <= {1'b0, cur.len} + 9'd1;
        DATA: if (r_hs) begin
          beat_cnt <= beat_cnt - 9'd1;
          // Termination is counter-driven; a stray or missing rlast only flags.
          if (m_axi_rresp != 2'b00 || m_axi_rlast != last_beat)
            dram_read_error <= 1'b1;
          if (last_beat && nxt_pend) begin
            cur      <= nxt;
            nxt_pend <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_dram_read_master.sv
// Bench for dram_read_master: AXI slave + consumer model driven on the falling
// edge, fixed vectors from a table, then random requests against a page-split model.
module tb_dram_read_master;
  localparam int AW = 39;
  localparam int DW = 128;

  typedef struct {
    logic [AW-1:0] addr;
    logic [7:0]    len;
  } ar_t;

  typedef struct {
    string         name;
    logic [AW-1:0] addr;
    logic [7:0]    len;
    int            arwait;
    int            fmode;
    bit            a5;
    int            rbad;
    bit            lbad;
    bit            poke;
    bit            pre_rst;
    int            n_ar;
    logic [AW-1:0] a1;
    logic [7:0]    l1;
    logic [AW-1:0] a2;
    logic [7:0]    l2;
    bit            eerr;
  } vec_t;

  logic s_axi_aclk = 0, s_axi_aresetn = 0;
  logic [AW-1:0] dram_read_addr = '0;
  logic [7:0]    dram_read_len = '0;
  logic          dram_read_en = 0, dram_buffer_full = 0;
  logic [DW-1:0] dram_read_data;
  logic          dram_read_data_valid, dram_read_busy, dram_read_error;
  logic [AW-1:0] m_axi_araddr;
  logic [7:0]    m_axi_arlen;
  logic [2:0]    m_axi_arsize;
  logic [1:0]    m_axi_arburst;
  logic [15:0]   m_axi_arid;
  logic          m_axi_arvalid, m_axi_arready = 0;
  logic [DW-1:0] m_axi_rdata = '0;
  logic [1:0]    m_axi_rresp = '0;
  logic          m_axi_rlast = 0, m_axi_rvalid = 0, m_axi_rready;
  logic [15:0]   m_axi_rid = 16'h0;

  dram_read_master dut (
    .s_axi_aclk(s_axi_aclk), .s_axi_aresetn(s_axi_aresetn),
    .dram_read_addr(dram_read_addr), .dram_read_len(dram_read_len),
    .dram_read_en(dram_read_en), .dram_buffer_full(dram_buffer_full),
    .dram_read_data(dram_read_data), .dram_read_data_valid(dram_read_data_valid),
    .dram_read_busy(dram_read_busy), .dram_read_error(dram_read_error),
    .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
    .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst),
    .m_axi_arid(m_axi_arid), .m_axi_arvalid(m_axi_arvalid),
    .m_axi_arready(m_axi_arready), .m_axi_rdata(m_axi_rdata),
    .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
    .m_axi_rid(m_axi_rid)
  );

  always #5 s_axi_aclk = ~s_axi_aclk;

  int tests = 0, fails = 0, prot_err = 0;

  // slave / consumer knobs, set by the main sequence before each request
  int ar_delay = 0, fmode = 0, rbad = -1, exp_beats = -1;
  bit rand_r = 0, lbad = 0, use_a5 = 0;

  ar_t           obs_ar[$];
  ar_t           exp_ar[$];
  logic [DW-1:0] obs_data[$];
  vec_t          vecs[$];

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] pat(input logic [AW-1:0] a, input bit a5);
    logic [31:0] w;
    w = a[31:0];
    if (a5) return {16{8'hA5}};
    return {w ^ 32'hDEADBEEF, w, ~w, w + 32'd1};
  endfunction

  // Reference split: N beats fit if N*BPB bytes remain in the 4 KiB page.
  function automatic void model_ars(input logic [AW-1:0] addr, input logic [7:0] len);
    longint a, n, left, b;
    ar_t r;
    exp_ar.delete();
    a    = longint'(addr) & ~longint'(15);
    n    = longint'(len) + 1;
    left = 4096 - (a % 4096);
    if (n * 16 <= left) begin
      r.addr = AW'(a); r.len = len; exp_ar.push_back(r);
    end else begin
      b = left / 16;
      r.addr = AW'(a);        r.len = 8'(b - 1);     exp_ar.push_back(r);
      r.addr = AW'(a + left); r.len = 8'(n - b - 1); exp_ar.push_back(r);
    end
  endfunction

  // AXI slave, consumer and protocol monitor
  initial begin : slave
    bit r_active = 0, hs_prev = 0, arv_stall = 0, bp_done = 0, ar_hs, r_hs;
    int r_idx = 0, ar_wait = 0, bp_left = 0;
    logic [AW-1:0] r_addr = '0, st_addr = '0;
    logic [7:0]    r_len = '0, st_len = '0;
    forever begin
      @(negedge s_axi_aclk);
      if (!s_axi_aresetn) begin
        r_active = 0; hs_prev = 0; arv_stall = 0; ar_wait = 0; bp_left = 0; bp_done = 0;
        m_axi_arready = 0; m_axi_rvalid = 0; m_axi_rlast = 0; dram_buffer_full = 0;
        continue;
      end
      if (exp_beats < 0) bp_done = 0;
      case (fmode)
        1: dram_buffer_full = ($urandom_range(0, 99) < 30);
        2: if (bp_left > 0) begin
             dram_buffer_full = 1; bp_left--;
           end else if (!bp_done && obs_data.size() >= 5) begin
             dram_buffer_full = 1; bp_left = 9; bp_done = 1;
           end else dram_buffer_full = 0;
        default: dram_buffer_full = 0;
      endcase
      m_axi_arready = m_axi_arvalid && (ar_wait >= ar_delay);
      if (r_active) begin
        m_axi_rvalid = rand_r ? ($urandom_range(0, 99) < 70) : 1'b1;
        m_axi_rdata  = pat(r_addr + AW'(r_idx * 16), use_a5);
        m_axi_rresp  = (r_idx == rbad) ? 2'b10 : 2'b00;
        m_axi_rlast  = lbad ? (r_idx == 1) : (r_idx == int'(r_len));
      end else begin
        m_axi_rvalid = 0; m_axi_rlast = 0; m_axi_rresp = 2'b00;
      end
      #1;
      if (dram_read_data_valid !== hs_prev) begin
        prot_err++; $display("proto: data_valid %0b after handshake %0b", dram_read_data_valid, hs_prev);
      end
      if (dram_read_data_valid === 1'b1) begin
        obs_data.push_back(dram_read_data);
        if (obs_data.size() == exp_beats) check("busy_fall_on_last_beat", 64'(dram_read_busy), 0);
      end
      if (dram_buffer_full && m_axi_rready) begin
        prot_err++; $display("proto: rready high while buffer full");
      end
      if (!r_active && m_axi_rready) begin
        prot_err++; $display("proto: rready high with no burst accepted");
      end
      if (arv_stall && (!m_axi_arvalid || m_axi_araddr != st_addr || m_axi_arlen != st_len)) begin
        prot_err++; $display("proto: AR changed before arready");
      end
      ar_hs     = m_axi_arvalid && m_axi_arready;
      r_hs      = m_axi_rvalid && m_axi_rready;
      arv_stall = m_axi_arvalid && !m_axi_arready;
      st_addr   = m_axi_araddr;
      st_len    = m_axi_arlen;
      if (arv_stall) ar_wait++;
      if (r_hs) begin
        r_idx++;
        if (r_idx > int'(r_len)) r_active = 0;
      end
      if (ar_hs) begin
        if (r_active) begin
          prot_err++; $display("proto: AR issued while a burst is still draining");
        end
        obs_ar.push_back('{m_axi_araddr, m_axi_arlen});
        r_active = 1; r_addr = m_axi_araddr; r_len = m_axi_arlen; r_idx = 0; ar_wait = 0;
      end
      hs_prev = r_hs;
    end
  end

  task automatic pulse_reset();
    @(negedge s_axi_aclk);
    s_axi_aresetn = 0;
    repeat (2) @(negedge s_axi_aclk);
    #3 s_axi_aresetn = 1;
  endtask

  // Issue one request and compare ARs, beats, data, error flag and protocol.
  task automatic run_req(input string nm, input logic [AW-1:0] addr, input logic [7:0] len,
                         input bit poke, input bit eerr);
    int n, base, bad, c;
    logic [AW-1:0] a;
    n = int'(len) + 1;
    base = prot_err;
    obs_ar.delete(); obs_data.delete();
    exp_beats = n;
    @(negedge s_axi_aclk);
    dram_read_addr = addr; dram_read_len = len; dram_read_en = 1;
    @(negedge s_axi_aclk);
    dram_read_en = 0;
    #2 check({nm, "_arvalid_busy_cycle1"}, {62'd0, m_axi_arvalid, dram_read_busy}, 64'd3);
    if (poke) begin
      @(negedge s_axi_aclk);
      dram_read_addr = 39'h12340; dram_read_len = 8'd5; dram_read_en = 1;
      @(negedge s_axi_aclk);
      dram_read_en = 0;
    end
    for (c = 0; c < 5000 && obs_data.size() < n; c++) @(negedge s_axi_aclk);
    repeat (4) @(negedge s_axi_aclk);
    #2;
    check({nm, "_beats"}, 64'(obs_data.size()), 64'(n));
    bad = 0;
    a = addr & ~AW'(15);
    for (int k = 0; k < obs_data.size() && k < n; k++)
      if (obs_data[k] !== pat(a + AW'(k * 16), use_a5)) begin
        if (bad == 0) $display("  %s first bad beat %0d: got %h want %h", nm, k, obs_data[k],
                               pat(a + AW'(k * 16), use_a5));
        bad++;
      end
    check({nm, "_data_mismatches"}, 64'(bad), 0);
    check({nm, "_ar_count"}, 64'(obs_ar.size()), 64'(exp_ar.size()));
    for (int i = 0; i < obs_ar.size() && i < exp_ar.size(); i++) begin
      check({nm, "_araddr"}, 64'(obs_ar[i].addr), 64'(exp_ar[i].addr));
      check({nm, "_arlen"}, 64'(obs_ar[i].len), 64'(exp_ar[i].len));
    end
    check({nm, "_error"}, 64'(dram_read_error), 64'(eerr));
    check({nm, "_busy_idle"}, 64'(dram_read_busy), 0);
    check({nm, "_protocol"}, 64'(prot_err - base), 0);
    exp_beats = -1;
  endtask

  task automatic add_vec(input string nm, input logic [AW-1:0] addr, input logic [7:0] len,
                         input int arwait, input int fm, input bit a5, input int rb, input bit lb,
                         input bit pk, input bit pr, input int n_ar,
                         input logic [AW-1:0] a1, input logic [7:0] l1,
                         input logic [AW-1:0] a2, input logic [7:0] l2, input bit eerr);
    vec_t v;
    v.name = nm; v.addr = addr; v.len = len; v.arwait = arwait; v.fmode = fm; v.a5 = a5;
    v.rbad = rb; v.lbad = lb; v.poke = pk; v.pre_rst = pr; v.n_ar = n_ar;
    v.a1 = a1; v.l1 = l1; v.a2 = a2; v.l2 = l2; v.eerr = eerr;
    vecs.push_back(v);
  endtask

  initial begin : main
    ar_t r;
    logic [AW-1:0] a;
    logic [7:0] l;
    int c;

    // name addr len arwait fmode a5 rbad lbad poke pre_rst n_ar a1 l1 a2 l2 err
    add_vec("single",     39'h1000,       8'd0,   0, 0, 1, -1, 0, 0, 0, 1, 39'h1000,       8'd0,   '0,       8'd0, 0);
    add_vec("aligned16",  39'h2000,       8'd15,  5, 0, 0, -1, 0, 1, 0, 1, 39'h2000,       8'd15,  '0,       8'd0, 0);
    add_vec("split4k",    39'h0F80,       8'd15,  0, 0, 0, -1, 0, 0, 0, 2, 39'h0F80,       8'd7,   39'h1000, 8'd7, 0);
    add_vec("backpress",  39'h3000,       8'd15,  0, 2, 0, -1, 0, 0, 0, 1, 39'h3000,       8'd15,  '0,       8'd0, 0);
    add_vec("unaligned",  39'h400F,       8'd3,   1, 0, 0, -1, 0, 0, 0, 1, 39'h4000,       8'd3,   '0,       8'd0, 0);
    add_vec("exact_fit",  39'h5F00,       8'd15,  0, 0, 0, -1, 0, 0, 0, 1, 39'h5F00,       8'd15,  '0,       8'd0, 0);
    add_vec("max_page",   39'h6000,       8'd255, 0, 0, 0, -1, 0, 0, 0, 1, 39'h6000,       8'd255, '0,       8'd0, 0);
    add_vec("max_split",  39'h7010,       8'd255, 0, 0, 0, -1, 0, 0, 0, 2, 39'h7010,       8'd254, 39'h8000, 8'd0, 0);
    add_vec("addr_wrap",  39'h7FFFFFFFC0, 8'd7,   0, 0, 0, -1, 0, 0, 0, 2, 39'h7FFFFFFFC0, 8'd3,   39'h0,    8'd3, 0);
    add_vec("rresp_err",  39'h9000,       8'd3,   0, 0, 0,  2, 0, 0, 0, 1, 39'h9000,       8'd3,   '0,       8'd0, 1);
    add_vec("rlast_err",  39'hA000,       8'd3,   0, 0, 0, -1, 1, 0, 1, 1, 39'hA000,       8'd3,   '0,       8'd0, 1);

    s_axi_aresetn = 0;
    repeat (3) @(negedge s_axi_aclk);
    #2;
    check("rst_arvalid", 64'(m_axi_arvalid), 0);
    check("rst_rready", 64'(m_axi_rready), 0);
    check("rst_busy_valid_err", {61'd0, dram_read_busy, dram_read_data_valid, dram_read_error}, 0);
    check("rst_araddr_arlen", {17'd0, m_axi_araddr, m_axi_arlen}, 0);
    check("rst_data", 64'(dram_read_data[127:64] | dram_read_data[63:0]), 0);
    check("const_arsize_arburst_arid", {43'd0, m_axi_arsize, m_axi_arburst, m_axi_arid}, {43'd0, 3'd4, 2'b01, 16'd0});
    #1 s_axi_aresetn = 1;

    foreach (vecs[i]) begin
      if (vecs[i].pre_rst) pulse_reset();
      ar_delay = vecs[i].arwait; fmode = vecs[i].fmode; use_a5 = vecs[i].a5;
      rbad = vecs[i].rbad; lbad = vecs[i].lbad; rand_r = 0;
      exp_ar.delete();
      r.addr = vecs[i].a1; r.len = vecs[i].l1; exp_ar.push_back(r);
      if (vecs[i].n_ar == 2) begin
        r.addr = vecs[i].a2; r.len = vecs[i].l2; exp_ar.push_back(r);
      end
      run_req(vecs[i].name, vecs[i].addr, vecs[i].len, vecs[i].poke, vecs[i].eerr);
    end
    ar_delay = 0; fmode = 0; use_a5 = 0; rbad = -1; lbad = 0;

    // reset in the middle of a data phase
    obs_data.delete(); obs_ar.delete();
    exp_beats = 100;
    @(negedge s_axi_aclk);
    dram_read_addr = 39'hB000; dram_read_len = 8'd15; dram_read_en = 1;
    @(negedge s_axi_aclk);
    dram_read_en = 0;
    for (c = 0; c < 200 && obs_data.size() < 4; c++) @(negedge s_axi_aclk);
    check("midrst_reached_data", 64'(obs_data.size() >= 4), 1);
    #3 s_axi_aresetn = 0;
    #1;
    check("midrst_arvalid", 64'(m_axi_arvalid), 0);
    check("midrst_rready", 64'(m_axi_rready), 0);
    check("midrst_busy", 64'(dram_read_busy), 0);
    check("midrst_valid", 64'(dram_read_data_valid), 0);
    check("midrst_error_cleared", 64'(dram_read_error), 0);
    repeat (2) @(negedge s_axi_aclk);
    #3 s_axi_aresetn = 1;
    exp_beats = -1;
    model_ars(39'hC0F0, 8'd4);
    run_req("after_reset", 39'hC0F0, 8'd4, 0, 0);

    // randomized traffic against the page-split model
    for (int t = 0; t < 40; t++) begin
      case ($urandom_range(0, 2))
        0: a = AW'({$urandom(), $urandom()});
        1: begin
             a = AW'({$urandom(), $urandom()});
             a = {a[AW-1:12], 12'h000} + AW'(4096 - 16 * $urandom_range(1, 20));
           end
        default: a = 39'h7FFFFFF000 + AW'(16 * $urandom_range(200, 255));
      endcase
      l = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(100, 255)) : 8'($urandom_range(0, 40));
      ar_delay = $urandom_range(0, 3);
      fmode = $urandom_range(0, 1);
      rand_r = 1;
      model_ars(a, l);
      run_req($sformatf("rand%0d", t), a, l, (l >= 8) && ($urandom_range(0, 2) == 0), 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
